// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: expands one 512-bit block into W[0..ROUNDS-1]
// through a 16-word sliding window, one word per valid/ready handshake.
module sha256_msg_schedule #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] blk_in,
  input  logic         blk_valid,
  output logic         blk_ready,
  output logic [31:0]  w_out,
  output logic [5:0]   w_idx,
  output logic         w_valid,
  input  logic         w_ready,
  output logic         sched_done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [5:0] LAST = 6'(ROUNDS - 1);

  state_t      state_q, state_d;
  logic [31:0] window_q [16];
  logic [31:0] window_d [16];
  logic [31:0] blk_word [16];
  logic [5:0]  count_q, count_d;
  logic        done_q, done_d;
  logic        load, xfer, last;
  logic [31:0] new_w;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // W0 occupies the most significant word of the block
  for (genvar gi = 0; gi < 16; gi++) begin : g_unpack
    assign blk_word[gi] = blk_in[511-32*gi -: 32];
  end

  assign new_w = sig1(window_q[14]) + window_q[9] + sig0(window_q[1]) + window_q[0];
  assign last  = (count_q == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < 16; i++) window_q[i] <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
      for (int i = 0; i < 16; i++) window_q[i] <= window_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    load    = 1'b0;
    xfer    = 1'b0;
    case (state_q)
      IDLE: begin
        if (blk_valid) begin
          load    = 1'b1;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (w_ready) begin
          xfer = 1'b1;
          if (last) begin
            state_d = IDLE;
            done_d  = 1'b1;
            count_d = '0;
          end else begin
            count_d = count_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    for (int i = 0; i < 16; i++) window_d[i] = window_q[i];
    if (load) begin
      for (int i = 0; i < 16; i++) window_d[i] = blk_word[i];
    end else if (xfer && !last) begin
      for (int i = 0; i < 15; i++) window_d[i] = window_q[i+1];
      window_d[15] = new_w;
    end
  end

  // Outputs decode registered state only; the window is masked outside RUN
  always_comb begin
    blk_ready  = (state_q == IDLE);
    w_valid    = (state_q == RUN);
    w_out      = (state_q == RUN) ? window_q[0] : 32'd0;
    w_idx      = (state_q == RUN) ? count_q : 6'd0;
    sched_done = done_q;
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Scoreboard bench for sha256_msg_schedule: each accepted block pushes its
// reference schedule; every emitted word is popped and compared.
module tb_sha256_msg_schedule;
  localparam int ROUNDS = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [511:0] blk_in = '0;
  logic         blk_valid = 1'b0;
  logic         w_ready = 1'b1;
  logic         blk_ready, w_valid, sched_done;
  logic [31:0]  w_out;
  logic [5:0]   w_idx;

  always #5 clk = ~clk;

  sha256_msg_schedule #(.ROUNDS(ROUNDS)) dut (
    .clk(clk), .rst(rst), .blk_in(blk_in), .blk_valid(blk_valid),
    .blk_ready(blk_ready), .w_out(w_out), .w_idx(w_idx), .w_valid(w_valid),
    .w_ready(w_ready), .sched_done(sched_done)
  );

  typedef struct {logic [5:0] idx; logic [31:0] w;} exp_t;

  int          n_checks = 0, n_pass = 0, cyc = 0;
  int          n_accept = 0, n_done = 0, accept_cyc = 0, done_cyc = 0, accept_gap = 0;
  bit          rand_mode = 0, model_run = 0, exp_done = 0, was_run = 0;
  exp_t        sb[$];
  exp_t        e;
  logic [31:0] obs [64];

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] s0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] s1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic push_block(input logic [511:0] b);
    logic [31:0] w [64];
    for (int t = 0; t < 16; t++) w[t] = b[511-32*t -: 32];
    for (int t = 16; t < 64; t++) w[t] = s1(w[t-2]) + w[t-7] + s0(w[t-15]) + w[t-16];
    for (int t = 0; t < ROUNDS; t++) sb.push_back('{6'(t), w[t]});
  endtask

  // Monitor / scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      sb.delete();
      model_run = 0;
      exp_done  = 0;
      chk("rst_blk_ready", 32'(blk_ready), 32'd1);
      chk("rst_w_valid", 32'(w_valid), 32'd0);
      chk("rst_sched_done", 32'(sched_done), 32'd0);
    end else begin
      was_run = model_run;
      chk("w_valid", 32'(w_valid), 32'(was_run));
      chk("blk_ready", 32'(blk_ready), 32'(!was_run));
      if (sched_done || exp_done) chk("sched_done", 32'(sched_done), 32'(exp_done));
      if (sched_done) begin
        n_done++;
        done_cyc = cyc;
      end
      exp_done = 0;
      if (was_run) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 32'd1, 32'd0);
        end else begin
          chk("w_out", w_out, sb[0].w);
          chk("w_idx", 32'(w_idx), 32'(sb[0].idx));
          if (w_ready) begin
            e = sb.pop_front();
            obs[e.idx] = w_out;
            $display("t=%0t word idx=%0d w=%h", $time, w_idx, w_out);
            if (e.idx == 6'(ROUNDS - 1)) begin
              model_run = 0;
              exp_done  = 1;
            end
          end
        end
      end else if (blk_valid) begin
        push_block(blk_in);
        model_run  = 1;
        n_accept++;
        accept_cyc = cyc;
        accept_gap = cyc - done_cyc;
        $display("t=%0t block accepted W0=%h", $time, blk_in[511:480]);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1 w_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic wait_accept(input int acc0);
    for (int i = 0; i < 300 && n_accept == acc0; i++) @(posedge clk);
    if (n_accept == acc0) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input logic [511:0] b);
    int acc0;
    acc0 = n_accept;
    @(posedge clk);
    #1 blk_in = b;
    blk_valid = 1'b1;
    wait_accept(acc0);
    #1 blk_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && (model_run || sb.size() != 0); i++) @(posedge clk);
    if (model_run || sb.size() != 0) chk("idle_timeout", 32'd0, 32'd1);
    repeat (2) @(posedge clk);
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 64; i++) obs[i] = 32'hDEADBEEF;
  endtask

  logic [511:0] abc, ones, blk_b;
  int d0, a0;

  initial begin
    abc  = {32'h61626380, {14{32'h0}}, 32'h00000018};
    ones = '1;
    for (int i = 0; i < 16; i++) blk_b[511-32*i -: 32] = 32'h9E3779B9 * 32'(i + 1);
    clear_obs();

    #1;
    chk("init_blk_ready", 32'(blk_ready), 32'd1);
    chk("init_w_valid", 32'(w_valid), 32'd0);
    chk("init_sched_done", 32'(sched_done), 32'd0);
    chk("init_w_out", w_out, 32'd0);
    chk("init_w_idx", 32'(w_idx), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_blk_ready", 32'(blk_ready), 32'd1);
    chk("post_rst_w_valid", 32'(w_valid), 32'd0);

    // abc block, consumer always ready
    d0 = n_done;
    send(abc);
    wait_idle();
    chk("abc_w16", obs[16], 32'h61626380);
    chk("abc_w17", obs[17], 32'h000F0000);
    chk("abc_w63", obs[63], 32'h12B1EDEB);
    chk("abc_done_latency", 32'(done_cyc - accept_cyc), 32'd65);
    chk("abc_done_count", 32'(n_done - d0), 32'd1);

    // all-ones block exercises mod-2^32 wrap
    clear_obs();
    send(ones);
    wait_idle();
    chk("ones_w0", obs[0], 32'hFFFFFFFF);
    chk("ones_w15", obs[15], 32'hFFFFFFFF);
    chk("ones_w16", obs[16], 32'h203FFFFC);

    // abc with randomly stalling consumer
    clear_obs();
    rand_mode = 1;
    d0 = n_done;
    send(abc);
    wait_idle();
    rand_mode = 0;
    chk("rand_w17", obs[17], 32'h000F0000);
    chk("rand_w63", obs[63], 32'h12B1EDEB);
    chk("rand_done_count", 32'(n_done - d0), 32'd1);

    // second block held valid throughout the first block's run
    a0 = n_accept;
    d0 = n_done;
    @(posedge clk);
    #1 blk_in = abc;
    blk_valid = 1'b1;
    wait_accept(a0);
    #1 blk_in = blk_b;
    wait_accept(a0 + 1);
    #1 blk_valid = 1'b0;
    chk("b2b_gap", 32'(accept_gap), 32'd0);
    wait_idle();
    chk("b2b_accepts", 32'(n_accept - a0), 32'd2);
    chk("b2b_done_count", 32'(n_done - d0), 32'd2);

    // asynchronous reset in the middle of a run
    send(abc);
    for (int i = 0; i < 300 && !(w_valid && w_idx == 6'd20); i++) @(negedge clk);
    chk("reached_idx20", 32'(w_idx), 32'd20);
    #2 rst = 1'b0;
    #1;
    chk("arst_blk_ready", 32'(blk_ready), 32'd1);
    chk("arst_w_valid", 32'(w_valid), 32'd0);
    chk("arst_w_out", w_out, 32'd0);
    chk("arst_w_idx", 32'(w_idx), 32'd0);
    chk("arst_sched_done", 32'(sched_done), 32'd0);
    d0 = n_done;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    chk("arst_no_done", 32'(n_done), 32'(d0));

    clear_obs();
    send(abc);
    wait_idle();
    chk("after_rst_w0", obs[0], 32'h61626380);
    chk("after_rst_w16", obs[16], 32'h61626380);
    chk("after_rst_w63", obs[63], 32'h12B1EDEB);
    chk("after_rst_done_count", 32'(n_done - d0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
